// File: rtl/montgomery_mult_param.sv
// -----------------------------------------------------------------------------
// montgomery_mult_param
//   Radix-2 Montgomery multiplier: result = A*B*2^-N mod M, fully reduced (< M).
//   One bit of A is consumed per clock. A final conditional subtract brings the
//   accumulator below M. Used by the RSA exponentiation controller as its
//   mont-mul / mont-square engine.
//
// Handshake: start is sampled only while idle and not in the done cycle. An
//   accepted start latches in_a/in_b/in_m. busy is high while the operation is
//   in flight. done pulses for one cycle when result is valid. If in_m is even,
//   the request is rejected: done and err pulse together and result is kept.
//
// Ports
//   clk         in   1  clock, rising edge
//   resetn      in   1  synchronous, active-low reset
//   start       in   1  operation request
//   in_a        in   N  operand A (< M)
//   in_b        in   N  operand B (< M)
//   in_m        in   N  modulus M (must be odd)
//   busy        out  1  operation in flight
//   done        out  1  one-cycle completion (or rejection) pulse
//   err         out  1  one-cycle pulse with done when in_m was even
//   result      out  N  last good result, held until next successful done
//   dbg_state_o out  2  FSM state (0 idle, 1 iterate, 2 subtract)
// -----------------------------------------------------------------------------
module montgomery_mult_param #(
  parameter int N     = 1024,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] result,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_SUB  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;          // shifts right; bit 0 is the current a_i
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   m_q, m_d;
  logic [N+1:0]   c_q, c_d;          // accumulator, always < 2M
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [N-1:0]   result_q, result_d;

  // Datapath for one bit-iteration and the final reduction.
  logic [N+1:0] t_sum;
  logic [N+1:0] q_sum;
  logic [N+1:0] diff;

  assign t_sum = c_q + (a_q[0] ? {2'b00, b_q} : '0);
  // Adding M when T is odd makes the sum even, so the shift is an exact /2.
  assign q_sum = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
  assign diff  = c_q - {2'b00, m_q};

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        // The done cycle belongs to the finishing operation, so a start
        // that coincides with done is not taken.
        if (start && !done_q) begin
          if (in_m[0]) begin
            a_d     = in_a;
            b_d     = in_b;
            m_d     = in_m;
            c_d     = '0;
            cnt_d   = '0;
            state_d = S_ITER;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_ITER: begin
        c_d   = q_sum >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        // diff[N+1] set means C < M, keep C as is.
        result_d = diff[N+1] ? c_q[N-1:0] : diff[N-1:0];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    err         = err_q;
    result      = result_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// -----------------------------------------------------------------------------
// tb_montgomery_mult_param
//   Directed bench for the N=8 Montgomery multiplier. The reference value is
//   found by searching x in [0,M) with x*2^N == A*B (mod M); expected results
//   and err flags are queued at acceptance and popped on each done.
// -----------------------------------------------------------------------------
module tb_montgomery_mult_param;

  localparam int N = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] in_m = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  montgomery_mult_param #(.N(N)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_m       (in_m),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .dbg_state_o(dbg_state)
  );

  // Scoreboard
  logic [N-1:0] exp_q[$];
  logic         exp_err_q[$];
  logic [N-1:0] last_good = '0;
  int           checks = 0;
  int           passes = 0;
  int           done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // x such that x * 2^N == A*B (mod M), found by exhaustive search.
  function automatic logic [N-1:0] model(input int m, input int a, input int b);
    int ab;
    ab = (a * b) % m;
    for (int x = 0; x < m; x++) begin
      if (((x << N) % m) == ab) return N'(x);
    end
    return '0;
  endfunction

  // Compare process: every done is matched against the queue.
  always @(negedge clk) begin : compare
    logic [N-1:0] er;
    logic         ee;
    if (resetn) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          er = exp_q.pop_front();
          ee = exp_err_q.pop_front();
          check("result", {24'd0, result}, {24'd0, er});
          check("err", {31'd0, err}, {31'd0, ee});
        end
      end else begin
        check("err_without_done", {31'd0, err}, 32'd0);
      end
    end
  end

  // Driver: one operation, with optional start pulses while busy / at done
  // and optional reset at iteration reset_at.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                        input bit pulse_mid, input bit pulse_done, input int reset_at);
    bit seen;
    bit aborted;
    seen = 1'b0;
    aborted = 1'b0;
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    in_m  = m;
    @(posedge clk);
    if (m[0]) begin
      exp_q.push_back(model(int'(m), int'(a), int'(b)));
      exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(last_good);
      exp_err_q.push_back(1'b1);
    end
    for (int k = 0; k <= N + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        in_a  = N'($urandom_range(0, 255));
        in_b  = N'($urandom_range(0, 255));
        in_m  = N'($urandom_range(0, 255));
      end
      if (reset_at == k) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        exp_err_q.delete();
        last_good = '0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        repeat (N + 4) begin
          @(negedge clk);
          check("post_reset_busy", {31'd0, busy}, 32'd0);
        end
        aborted = 1'b1;
        break;
      end
      if (done) begin
        seen = 1'b1;
        check("latency", k, m[0] ? N + 1 : 0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        break;
      end
      check("busy_in_flight", {31'd0, busy}, {31'd0, m[0]});
      if (pulse_mid && k == 3) begin
        start = 1'b1;
        in_a  = 8'd1;
        in_b  = 8'd1;
        in_m  = 8'd3;
      end
      if (pulse_mid && k == 4) start = 1'b0;
    end
    if (!aborted) begin
      if (!seen) check("done_timeout", {31'd0, done}, 32'd1);
      if (m[0] && seen) last_good = model(int'(m), int'(a), int'(b));
      if (pulse_done) begin
        // start coincides with done: must not be taken
        start = 1'b1;
        in_a  = 8'd3;
        in_b  = 8'd4;
        in_m  = 8'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 3) begin
          @(negedge clk);
          check("start_at_done_ignored", {31'd0, busy}, 32'd0);
        end
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int dc;
    logic [N-1:0] rm;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Pin the reference model with hand-computed values (2^-8 mod 13 = 3).
    check("model_5x7_mod13", {24'd0, model(13, 5, 7)}, 32'd1);
    check("model_1x9_mod13", {24'd0, model(13, 1, 9)}, 32'd1);
    check("model_0x12_mod13", {24'd0, model(13, 0, 12)}, 32'd0);
    check("model_2x2_mod3", {24'd0, model(3, 2, 2)}, 32'd1);

    // T1 / T2
    run_op(8'd5, 8'd7, 8'd13, 1'b0, 1'b0, -1);
    check("t1_result_literal", {24'd0, result}, 32'd1);
    run_op(8'd0, 8'd12, 8'd13, 1'b0, 1'b0, -1);
    check("t2a_result_literal", {24'd0, result}, 32'd0);
    run_op(8'd1, 8'd9, 8'd13, 1'b0, 1'b0, -1);
    check("t2b_result_literal", {24'd0, result}, 32'd1);

    // T3: even modulus rejected, result held
    run_op(8'd3, 8'd4, 8'd12, 1'b0, 1'b0, -1);
    check("t3_result_held", {24'd0, result}, 32'd1);
    check("t3_busy_low", {31'd0, busy}, 32'd0);

    // T4: start mid-iteration and coincident with done are ignored
    dc = done_cnt;
    run_op(8'd5, 8'd7, 8'd13, 1'b1, 1'b1, -1);
    check("t4_one_done", done_cnt - dc, 32'd1);
    check("t4_result", {24'd0, result}, 32'd1);

    // T5: reset at cnt=4, then a clean operation
    run_op(8'd200, 8'd100, 8'd251, 1'b0, 1'b0, 4);
    check("t5_result_cleared", {24'd0, result}, 32'd0);
    run_op(8'd5, 8'd7, 8'd13, 1'b0, 1'b0, -1);

    // Boundary operands
    run_op(8'd254, 8'd254, 8'd255, 1'b0, 1'b0, -1);
    run_op(8'd100, 8'd200, 8'd251, 1'b0, 1'b0, -1);
    run_op(8'd2, 8'd2, 8'd3, 1'b0, 1'b0, -1);
    run_op(8'd128, 8'd1, 8'd129, 1'b0, 1'b0, -1);
    run_op(8'd77, 8'd188, 8'd201, 1'b0, 1'b0, -1);
    run_op(8'd0, 8'd0, 8'd1, 1'b0, 1'b0, -1);
    run_op(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, -1);

    // Random odd moduli
    for (int i = 0; i < 20; i++) begin
      rm = N'($urandom_range(1, 127) * 2 + 1);
      ra = N'($urandom_range(0, int'(rm) - 1));
      rb = N'($urandom_range(0, int'(rm) - 1));
      run_op(ra, rb, rm, 1'b0, 1'b0, -1);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
